branch_resolve_unit: RTL

- Decode-stage branch resolver sitting directly downstream of the 32-bit equality comparator.
- Consumes the comparator's equal flag plus the decoded branch info, and decides BEQ/BNE taken or not-taken.
- Stalls while forwarded operands are not ready, then issues a one-cycle PC redirect and a multi-cycle pipeline flush.
- Keeps saturating branch statistics for the debug console.

---
 rtl/branch_resolve_unit_if.sv | 29 ++
 rtl/branch_resolve_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// Decode-to-branch-resolver bundle: branch info from decode and the comparator in,
// stall/redirect/flush/timeout and statistics out.
interface branch_resolve_unit_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             branch_valid;
    logic             branch_ne;
    logic             comp_equal;
    logic             operands_ready;
    logic [31:0]      pc_plus4;
    logic [31:0]      offset;
    logic             stall;
    logic             redirect;
    logic [31:0]      branch_target;
    logic             flush;
    logic             timeout;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output branch_valid, branch_ne, comp_equal, operands_ready, pc_plus4, offset,
        input  stall, redirect, branch_target, flush, timeout, branch_count, taken_count
    );

    modport slave (
        input  branch_valid, branch_ne, comp_equal, operands_ready, pc_plus4, offset,
        output stall, redirect, branch_target, flush, timeout, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Decode-stage BEQ/BNE resolver: waits for forwarded operands, then issues a PC redirect
// and a multi-cycle flush on taken branches, and keeps saturating branch statistics.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_WAIT     = 8,
    parameter int unsigned CNT_W        = 16
) (
    input logic                  clk,
    input logic                  reset,
    branch_resolve_unit_if.slave bru
);
    typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

    localparam logic [7:0]       MaxWait   = 8'(MAX_WAIT);
    localparam logic [3:0]       FlushLast = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             redirect_q, redirect_d;
    logic             timeout_q, timeout_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic             resolve;
    logic             taken;

    assign taken = bru.comp_equal ^ bru.branch_ne;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        resolve     = 1'b0;
        timeout_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bru.branch_valid) begin
                    if (bru.operands_ready) begin
                        resolve = 1'b1;
                    end else begin
                        state_d    = StWait;
                        wait_cnt_d = 8'd1;
                    end
                end
            end
            StWait: begin
                // Decode dropping the branch means it was squashed upstream: abandon quietly.
                if (!bru.branch_valid) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                end else if (bru.operands_ready) begin
                    resolve    = 1'b1;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == MaxWait) begin
                    state_d    = StIdle;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StFlush: begin
                if (flush_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (resolve) begin
            if (taken) begin
                state_d     = StFlush;
                flush_cnt_d = FlushLast;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        redirect_d   = resolve & taken;
        target_d     = target_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (resolve) begin
            if (branch_cnt_q != CntMax) branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (taken) begin
                target_d = bru.pc_plus4 + (bru.offset << 2);
                if (taken_cnt_q != CntMax) taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            redirect_q   <= 1'b0;
            timeout_q    <= 1'b0;
            target_q     <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            redirect_q   <= redirect_d;
            timeout_q    <= timeout_d;
            target_q     <= target_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    always_comb begin
        bru.stall = 1'b0;
        bru.flush = 1'b0;
        unique case (state_q)
            StIdle:  bru.stall = bru.branch_valid & ~bru.operands_ready;
            StWait:  bru.stall = ~bru.operands_ready;
            StFlush: bru.flush = 1'b1;
            default: bru.stall = 1'b0;
        endcase
        if (reset) bru.stall = 1'b0;
    end

    assign bru.redirect      = redirect_q;
    assign bru.timeout       = timeout_q;
    assign bru.branch_target = target_q;
    assign bru.branch_count  = branch_cnt_q;
    assign bru.taken_count   = taken_cnt_q;
endmodule
